// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory path.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x DATA_W word storage: synchronous byte-lane write, combinational read.
module dmem_bank
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [DATA_W/8-1:0]        be_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [DATA_W-1:0]          wd_i,
    output logic [DATA_W-1:0]          rd_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left uninitialised; there is no reset on the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < DATA_W / 8; k++) begin
                if (be_i[k]) begin
                    mem[addr_i][8*k +: 8] <= wd_i[8*k +: 8];
                end
            end
        end
    end

    assign rd_o = mem[addr_i];

endmodule

// File: rtl/dmem_wait.sv
// Data memory with WAIT_CYCLES wait states and a req/ready handshake for the M stage.
// Define DMEM_ERR_EN to report misaligned / out-of-range accesses on err_o.
module dmem_wait
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   wd_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rd_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state_q, state_d;
    logic [7:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q, acc_idx;
    logic              we_q, fault_q;
    logic [DATA_W-1:0] wd_q, rd_q, bank_rd;
    logic [BE_W-1:0]   be_q;
    logic              accept, acc_we, acc_fault, fault_in, bank_we, load_done;

    assign accept = (state_q == IDLE) && req_i;

`ifdef DMEM_ERR_EN
    assign fault_in = (a_i[1:0] != 2'b00) || (a_i[ADDR_W-1:IDX_W+2] != '0);
    assign err_o    = (state_q == DONE) && fault_q;
`else
    logic unused_a;
    assign unused_a = ^{a_i[ADDR_W-1:IDX_W+2], a_i[1:0]};
    assign fault_in = 1'b0;
    assign err_o    = 1'b0;
`endif

    // With zero wait states the load reads the array straight from the inputs.
    assign acc_idx   = (state_q == IDLE) ? a_i[IDX_W+1:2] : idx_q;
    assign acc_we    = (state_q == IDLE) ? we_i : we_q;
    assign acc_fault = (state_q == IDLE) ? fault_in : fault_q;

    assign bank_we   = (state_q == DONE) && we_q && !fault_q && !reset_i;
    assign load_done = (state_d == DONE) && (state_q != DONE) && !acc_we;

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk_i  (clk_i),
        .we_i   (bank_we),
        .be_i   (be_q),
        .addr_i (acc_idx),
        .wd_i   (wd_q),
        .rd_o   (bank_rd)
    );

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = req_i;
                if (req_i) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (cnt_q <= 8'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rd_q    <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            be_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q   <= a_i[IDX_W+1:2];
                we_q    <= we_i;
                wd_q    <= wd_i;
                be_q    <= be_i;
                fault_q <= fault_in;
                cnt_q   <= 8'(WAIT_CYCLES);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (load_done) begin
                rd_q <= acc_fault ? '0 : bank_rd;
            end
        end
    end

    assign rd_o = rd_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Randomised self-checking bench for dmem_wait against a word/byte-lane memory model.
module tb_dmem_wait;

    localparam int W = 2;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] a = '0, wd = '0;
    logic [3:0]  be = '0;
    logic [31:0] rd;
    logic        ready, busy, err;

    logic        req_z = 1'b0, we_z = 1'b0;
    logic [31:0] a_z = '0, wd_z = '0;
    logic [3:0]  be_z = '0;
    logic [31:0] rd_z;
    logic        ready_z, busy_z, err_z;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_data [64];
    logic [3:0]  m_val  [64];
    logic [31:0] last_rd;
    logic [3:0]  last_val;

    always #5 clk = ~clk;

    dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .a_i(a), .wd_i(wd),
        .be_i(be), .rd_o(rd), .ready_o(ready), .busy_o(busy), .err_o(err)
    );

    dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut_z (
        .clk_i(clk), .reset_i(reset), .req_i(req_z), .we_i(we_z), .a_i(a_z), .wd_i(wd_z),
        .be_i(be_z), .rd_o(rd_z), .ready_o(ready_z), .busy_o(busy_z), .err_o(err_z)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // One complete handshake on the main instance, checked against the model.
    task automatic access(input string tag, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] ben);
        bit f;
        int n;
        int idx;
        logic [31:0] exp;
        logic [31:0] msk;
        f   = ERR_EN && ((addr[1:0] != 2'b00) || (addr >= 32'd256));
        idx = int'(addr[7:2]);
        @(negedge clk);
        req = 1'b1; we = w; a = addr; wd = data; be = ben;
        #1;
        chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
        chk({tag, "_ready_acc"}, 32'(ready), 32'd0);
        n = 0;
        while (n < W + 4) begin
            @(negedge clk);
            n++;
            if (ready) break;
            chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
            we = 1'($urandom); a = $urandom; wd = $urandom; be = 4'($urandom);
        end
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(f));
        if (!w) begin
            exp = f ? 32'd0 : m_data[idx];
            msk = f ? 32'hFFFF_FFFF : lanes(m_val[idx]);
            chk({tag, "_rd"}, rd & msk, exp & msk);
            last_rd  = exp;
            last_val = f ? 4'hF : m_val[idx];
        end else begin
            msk = lanes(last_val);
            chk({tag, "_rd_hold"}, rd & msk, last_rd & msk);
            if (!f) begin
                msk = lanes(ben);
                m_data[idx] = (m_data[idx] & ~msk) | (data & msk);
                m_val[idx]  = m_val[idx] | ben;
            end
        end
        req = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(ready), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] addr;
        for (int i = 0; i < 64; i++) begin
            m_data[i] = '0;
            m_val[i]  = '0;
        end
        last_rd  = '0;
        last_val = 4'hF;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd", rd, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_z_ready", 32'(ready_z), 32'd0);

        access("t1_st", 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF);
        access("t1_ld", 1'b0, 32'h08, 32'h0, 4'h0);
        chk("t1_val", rd, 32'hDEAD_BEEF);

        access("t2_st", 1'b1, 32'h08, 32'h0000_00AA, 4'b0001);
        access("t2_ld", 1'b0, 32'h08, 32'h0, 4'h0);
        chk("t2_val", rd, 32'hDEAD_BEAA);

        access("t4_init", 1'b1, 32'h000, 32'h5555_0000, 4'hF);
        access("t4_st", 1'b1, 32'h100, 32'h0000_0011, 4'hF);
        access("t4_ld", 1'b0, 32'h000, 32'h0, 4'h0);
        chk("t4_val", rd, ERR_EN ? 32'h5555_0000 : 32'h0000_0011);

        access("t6_ld", 1'b0, 32'h0A, 32'h0, 4'h0);

        // Reset in the middle of a store: no pulse, word untouched.
        access("t5_init", 1'b1, 32'h14, 32'h1234_5678, 4'hF);
        @(negedge clk);
        req = 1'b1; we = 1'b1; a = 32'h14; wd = 32'hFFFF_0000; be = 4'hF;
        @(negedge clk);
        chk("t5_ready_c1", 32'(ready), 32'd0);
        @(negedge clk);
        chk("t5_ready_c2", 32'(ready), 32'd0);
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("t5_ready", 32'(ready), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_rd", rd, 32'd0);
        reset = 1'b0;
        last_rd = '0;
        last_val = 4'hF;
        @(negedge clk);
        chk("t5_ready_post", 32'(ready), 32'd0);
        access("t5_ld", 1'b0, 32'h14, 32'h0, 4'h0);
        chk("t5_val", rd, 32'h1234_5678);

        // Zero wait states: one-cycle latency, no acceptance from DONE.
        v = $urandom;
        @(negedge clk);
        req_z = 1'b1; we_z = 1'b1; a_z = 32'h8; wd_z = v; be_z = 4'hF;
        #1;
        chk("t3_busy_c0", 32'(busy_z), 32'd1);
        chk("t3_ready_c0", 32'(ready_z), 32'd0);
        @(negedge clk);
        chk("t3_ready_c1", 32'(ready_z), 32'd1);
        chk("t3_busy_c1", 32'(busy_z), 32'd0);
        chk("t3_err_c1", 32'(err_z), 32'd0);
        we_z = 1'b0;
        #1;
        chk("t3_busy_done", 32'(busy_z), 32'd0);
        @(negedge clk);
        chk("t3_ready_c2", 32'(ready_z), 32'd0);
        chk("t3_busy_c2", 32'(busy_z), 32'd1);
        @(negedge clk);
        chk("t3_ready_c3", 32'(ready_z), 32'd1);
        chk("t3_rd", rd_z, v);
        req_z = 1'b0;
        @(negedge clk);
        chk("t3_ready_c4", 32'(ready_z), 32'd0);
        chk("t3_busy_c4", 32'(busy_z), 32'd0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 7) addr = 32'($urandom_range(0, 63)) << 2;
            else addr = 32'($urandom_range(0, 1023));
            access("rnd", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rnd_idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
